key_debounce4: RTL and testbench

//  Four-channel push-button conditioner feeding the lock FSM's key_in[3:0].
//  Per key: 2-FF synchroniser, stable-time debounce filter, press-edge detector.

---
 rtl/key_debounce4.sv | 171 +++++++++++++++++
 tb/tb_key_debounce4.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce4.sv
// key_debounce4: four independent active-low key channels, each with a 2-FF synchroniser,
// stable-time debounce FSM and press pulse. Define KEY_REPEAT_EN for auto-repeat of held keys.
module key_debounce4 #(
  parameter int DEB_CYC  = 1_000_000,
  parameter int CNT_W    = 20,
  parameter int HOLD_CYC = 50_000_000,
  parameter int RPT_CYC  = 10_000_000,
  parameter int RPT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  output logic [3:0] key_pulse,
  output logic [3:0] key_level
);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       w_s;
  state_t           r_state     [4];
  state_t           w_state_nxt [4];
  logic [CNT_W-1:0] r_cnt       [4];
  logic [CNT_W-1:0] w_cnt_nxt   [4];
  logic [3:0]       r_pulse;
  logic [3:0]       r_level;
  logic [3:0]       w_pulse_nxt;
  logic [3:0]       w_level_nxt;
  logic [3:0]       w_rpt_pulse;

  // Synchroniser FFs hold the raw pin polarity, so reset to 1 means "released".
  assign w_s = ~r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_pulse <= '0;
      r_level <= '0;
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= RELEASED;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_pulse <= w_pulse_nxt | w_rpt_pulse;
      r_level <= w_level_nxt;
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Level and pulse are taken from the next state so they appear with the transition edge.
  always_comb begin
    w_pulse_nxt = '0;
    w_level_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        RELEASED: begin
          if (w_s[i]) begin
            w_state_nxt[i] = PRESS_CHK;
            w_cnt_nxt[i]   = '0;
          end
        end
        PRESS_CHK: begin
          if (!w_s[i]) begin
            w_state_nxt[i] = RELEASED;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == DEB_LAST) begin
            w_state_nxt[i] = PRESSED;
            w_cnt_nxt[i]   = '0;
            w_pulse_nxt[i] = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
          end
        end
        PRESSED: begin
          if (!w_s[i]) begin
            w_state_nxt[i] = REL_CHK;
            w_cnt_nxt[i]   = '0;
          end
        end
        REL_CHK: begin
          if (w_s[i]) begin
            w_state_nxt[i] = PRESSED;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == DEB_LAST) begin
            w_state_nxt[i] = RELEASED;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
          end
        end
        default: begin
          w_state_nxt[i] = RELEASED;
          w_cnt_nxt[i]   = '0;
        end
      endcase
      w_level_nxt[i] = (w_state_nxt[i] == PRESSED) || (w_state_nxt[i] == REL_CHK);
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYC - 1);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(RPT_CYC - 1);

  logic [RPT_W-1:0] r_rc      [4];
  logic [RPT_W-1:0] w_rc_nxt  [4];
  logic [3:0]       r_rpt;
  logic [3:0]       w_rpt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rpt <= '0;
      for (int i = 0; i < 4; i++) begin
        r_rc[i] <= '0;
      end
    end else begin
      r_rpt <= w_rpt_nxt;
      for (int i = 0; i < 4; i++) begin
        r_rc[i] <= w_rc_nxt[i];
      end
    end
  end

  // r_rpt marks that the initial hold has elapsed, after which rc counts repeat periods.
  always_comb begin
    w_rpt_pulse = '0;
    w_rpt_nxt   = r_rpt;
    for (int i = 0; i < 4; i++) begin
      w_rc_nxt[i] = r_rc[i];
      if ((r_state[i] == PRESSED) && w_s[i]) begin
        if (!r_rpt[i] && (r_rc[i] == HOLD_LAST)) begin
          w_rpt_pulse[i] = 1'b1;
          w_rpt_nxt[i]   = 1'b1;
          w_rc_nxt[i]    = '0;
        end else if (r_rpt[i] && (r_rc[i] == RPT_LAST)) begin
          w_rpt_pulse[i] = 1'b1;
          w_rc_nxt[i]    = '0;
        end else begin
          w_rc_nxt[i] = r_rc[i] + 1'b1;
        end
      end else begin
        w_rpt_nxt[i] = 1'b0;
        w_rc_nxt[i]  = '0;
      end
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{HOLD_CYC, RPT_CYC, RPT_W};
  assign w_rpt_pulse  = '0;
`endif

  assign key_pulse = r_pulse;
  assign key_level = r_level;

endmodule

// File: tb/tb_key_debounce4.sv
// tb_key_debounce4: directed stimulus for key_debounce4; expected press pulses go to a
// scoreboard queue checked by a negedge monitor, levels are checked inline.
module tb_key_debounce4;

  localparam int DEB_CYC  = 8;
  localparam int CNT_W    = 4;
  localparam int HOLD_CYC = 20;
  localparam int RPT_CYC  = 5;
  localparam int RPT_W    = 5;
  localparam int LAT      = 2 + DEB_CYC + 1;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } pulse_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic [3:0] key_pulse;
  logic [3:0] key_level;

  int     cyc         = 0;
  int     testsRun    = 0;
  int     testsFailed = 0;
  pulse_t sbQ[$];

  key_debounce4 #(
    .DEB_CYC  (DEB_CYC),
    .CNT_W    (CNT_W),
    .HOLD_CYC (HOLD_CYC),
    .RPT_CYC  (RPT_CYC),
    .RPT_W    (RPT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .key_pulse (key_pulse),
    .key_level (key_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic [3:0] kn);
    @(negedge clk);
    key_n = kn;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expectPulse(input int c, input logic [3:0] v);
    pulse_t e;
    e.cyc = c;
    e.val = v;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every nonzero pulse cycle must match the next queued expectation in both value and cycle.
  always @(negedge clk) begin
    pulse_t e;
    if (key_pulse !== 4'b0000) begin
      testsRun++;
      if (sbQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected_pulse: got %b at cycle %0d, expected no pulse", key_pulse, cyc);
      end else begin
        e = sbQ.pop_front();
        if ((e.cyc != cyc) || (e.val !== key_pulse)) begin
          testsFailed++;
          $display("[TB] FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d",
                   key_pulse, cyc, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   t;
    logic b;

    // Reset with keys released, then stay idle.
    waitCycles(3);
    checkOutput("reset_pulse", key_pulse, 4'b0000);
    checkOutput("reset_level", key_level, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      waitCycles(10);
      checkOutput("idle_level", key_level, 4'b0000);
    end

    // Clean press on key 0, held long enough for any auto-repeat.
    applyStimulus(4'b1110);
    t = cyc;
    expectPulse(t + LAT, 4'b0001);
`ifdef KEY_REPEAT_EN
    for (int k = 0; k < 5; k++) expectPulse(t + LAT + HOLD_CYC + k * RPT_CYC, 4'b0001);
`endif
    waitCycles(LAT - 1);
    checkOutput("press_level_early", key_level, 4'b0000);
    waitCycles(1);
    checkOutput("press_level", key_level, 4'b0001);
    waitCycles(39);
    checkOutput("held_level", key_level, 4'b0001);

    // Short release glitch while key 0 is held.
    applyStimulus(4'b1111);
    t = cyc;
    for (int i = 0; i < 3; i++) begin
      waitCycles(1);
      checkOutput("glitch_level", key_level, 4'b0001);
    end
    applyStimulus(4'b1110);
`ifdef KEY_REPEAT_EN
    expectPulse(t + 27, 4'b0001);
`endif
    for (int i = 0; i < 6; i++) begin
      waitCycles(1);
      checkOutput("glitch_recover_level", key_level, 4'b0001);
    end
    waitCycles(17);
    applyStimulus(4'b1111);
    t = cyc;
    waitCycles(LAT - 1);
    checkOutput("k0_release_level_early", key_level, 4'b0001);
    waitCycles(1);
    checkOutput("k0_release_level", key_level, 4'b0000);

    // Bouncing key 1: low runs of 3 cycles never pass the filter.
    for (int i = 0; i < 40; i++) begin
      b = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      applyStimulus({2'b11, b, 1'b1});
      checkOutput("bounce_level", key_level, 4'b0000);
    end
    applyStimulus(4'b1111);
    for (int i = 0; i < LAT + 2; i++) begin
      waitCycles(1);
      checkOutput("bounce_settle_level", key_level, 4'b0000);
    end

    // Keys 2 and 3 together, then released together.
    applyStimulus(4'b0011);
    t = cyc;
    expectPulse(t + LAT, 4'b1100);
    waitCycles(LAT);
    checkOutput("dual_level", key_level, 4'b1100);
    waitCycles(3);
    applyStimulus(4'b1111);
    waitCycles(LAT - 1);
    checkOutput("dual_release_early", key_level, 4'b1100);
    waitCycles(1);
    checkOutput("dual_release_level", key_level, 4'b0000);
    waitCycles(3);

    // Reset during a held press; the held key counts as a new press afterwards.
    applyStimulus(4'b1110);
    t = cyc;
    expectPulse(t + LAT, 4'b0001);
    waitCycles(LAT + 3);
    checkOutput("pre_rst_level", key_level, 4'b0001);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_pulse", key_pulse, 4'b0000);
    checkOutput("mid_rst_level", key_level, 4'b0000);
    waitCycles(3);
    rst = 1'b0;
    t = cyc;
    expectPulse(t + LAT, 4'b0001);
    waitCycles(LAT - 1);
    checkOutput("post_rst_level_early", key_level, 4'b0000);
    waitCycles(1);
    checkOutput("post_rst_level", key_level, 4'b0001);
    applyStimulus(4'b1111);
    waitCycles(LAT + 2);
    checkOutput("final_level", key_level, 4'b0000);

    waitCycles(5);
    testsRun++;
    if (sbQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL pending_pulses: %0d expected pulses never seen, required 0", sbQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
